// File: rtl/if_pc_ctrl_pkg.sv
// Shared definitions for the instruction-fetch PC controller.
// Holds the fetch FSM state encoding and the sequential PC step.
package if_pc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        DELIVER = 3'd3,
        KILL    = 3'd4
    } fetch_state_e;

    localparam int unsigned PcIncrement = 4;

endpackage

// File: rtl/if_pc_ctrl.sv
// Instruction-fetch PC controller: one outstanding imem fetch, handoff to decode
// with stall backpressure, and execute-stage redirects that squash in-flight work.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | just out of reset, no request offered yet
// REQ     | offering a fetch of pc_q to instruction memory
// WAIT    | fetch accepted, waiting for the response
// DELIVER | instruction presented to decode until stall drops
// KILL    | a squashed fetch is in flight; its response will be discarded
module if_pc_ctrl
    import if_pc_ctrl_pkg::*;
#(
    parameter int unsigned           WordSize    = 32,
    parameter logic [WordSize-1:0]   ResetVector = '0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                redirect_valid,
    input  logic [WordSize-1:0] redirect_addr,
    input  logic                stall,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [WordSize-1:0] imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [WordSize-1:0] imem_rsp_data,
    output logic                inst_valid,
    output logic [WordSize-1:0] inst,
    output logic [WordSize-1:0] inst_pc
);

    fetch_state_e        state_q, state_d;
    logic [WordSize-1:0] pc_q, pc_d;
    logic [WordSize-1:0] inst_q, inst_d;
    logic [WordSize-1:0] inst_pc_q, inst_pc_d;
    logic                inst_valid_q, inst_valid_d;

    logic                req_xfer;
    logic [WordSize-1:0] redirect_pc;
    logic [WordSize-1:0] pc_next_seq;

    always_comb begin
        req_xfer    = (state_q == REQ) && imem_req_ready;
        redirect_pc = redirect_addr & ~(WordSize'(3));
        pc_next_seq = pc_q + WordSize'(PcIncrement);
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;

        if (redirect_valid) begin
            // A redirect wins over everything; the only question is whether a
            // fetch is still in flight whose response must be swallowed.
            pc_d         = redirect_pc;
            inst_valid_d = 1'b0;
            case (state_q)
                IDLE:    state_d = REQ;
                REQ:     state_d = req_xfer ? KILL : REQ;
                WAIT:    state_d = imem_rsp_valid ? REQ : KILL;
                DELIVER: state_d = REQ;
                KILL:    state_d = imem_rsp_valid ? REQ : KILL;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = REQ;
                end
                REQ: begin
                    if (req_xfer) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        inst_d       = imem_rsp_data;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_next_seq;
                        state_d      = DELIVER;
                    end
                end
                DELIVER: begin
                    if (!stall) begin
                        inst_valid_d = 1'b0;
                        state_d      = REQ;
                    end
                end
                KILL: begin
                    if (imem_rsp_valid) begin
                        state_d = REQ;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            pc_q         <= ResetVector;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    always_comb begin
        imem_req_valid = (state_q == REQ);
        imem_req_addr  = pc_q;
        inst_valid     = inst_valid_q;
        inst           = inst_q;
        inst_pc        = inst_pc_q;
    end

endmodule

// File: tb/tb_if_pc_ctrl.sv
// Self-checking bench for if_pc_ctrl: an imem model with programmable latency,
// request/delivery scoreboards, and a second instance with a wrapping reset vector.
module tb_if_pc_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } deliv_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    logic        w_rstn;
    logic        w_req_valid;
    logic        w_ready;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_rsp_data;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] exp_req[$];
    deliv_t      exp_deliv[$];
    int          deliv_cyc[$];
    logic [31:0] w_exp_req[$];
    logic [31:0] w_deliv_pc[$];
    logic [31:0] w_deliv_inst[$];
    logic        prev_valid   = 1'b0;
    logic        w_prev_valid = 1'b0;

    always #5 clk = ~clk;

    if_pc_ctrl #(.WordSize(32), .ResetVector(32'h0000_0000)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    if_pc_ctrl #(.WordSize(32), .ResetVector(32'hFFFF_FFFC)) dut_wrap (
        .clk            (clk),
        .rstn           (w_rstn),
        .redirect_valid (1'b0),
        .redirect_addr  (32'h0),
        .stall          (1'b0),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (w_ready),
        .imem_req_addr  (w_req_addr),
        .imem_rsp_valid (w_rsp_valid),
        .imem_rsp_data  (w_rsp_data),
        .inst_valid     (w_inst_valid),
        .inst           (w_inst),
        .inst_pc        (w_inst_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: responds mem_lat cycles after an accepted request.
    int          mem_lat  = 1;
    logic        mem_pend = 1'b0;
    logic [1:0]  mem_cnt  = 2'd0;
    logic [31:0] mem_addr = 32'h0;

    always @(posedge clk) begin
        if (mem_pend) begin
            if (mem_cnt == 2'd0) mem_pend <= 1'b0;
            else                 mem_cnt  <= mem_cnt - 2'd1;
        end
        if (imem_req_valid && imem_req_ready) begin
            mem_pend <= 1'b1;
            mem_cnt  <= 2'(mem_lat - 1);
            mem_addr <= imem_req_addr;
        end
    end

    assign imem_rsp_valid = mem_pend && (mem_cnt == 2'd0);
    assign imem_rsp_data  = mem_word(mem_addr);

    always @(posedge clk) w_rsp_valid <= w_req_valid && w_ready;
    assign w_rsp_data = 32'h0000_0013;

    // Advance one cycle: scoreboard sampling on the falling edge, then return
    // just after the next rising edge so callers can drive inputs.
    task automatic tick();
        logic [31:0] a;
        deliv_t      e;
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            checks++;
            if (exp_req.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected addr got=%h exp=none", imem_req_addr);
            end else begin
                a = exp_req.pop_front();
                if (imem_req_addr !== a) begin
                    errors++;
                    $display("FAIL req_addr got=%h exp=%h", imem_req_addr, a);
                end
            end
        end
        if (inst_valid && !prev_valid) begin
            checks++;
            deliv_cyc.push_back(cyc);
            if (exp_deliv.size() == 0) begin
                errors++;
                $display("FAIL deliv_unexpected pc got=%h inst got=%h exp=none", inst_pc, inst);
            end else begin
                e = exp_deliv.pop_front();
                if (inst_pc !== e.pc || inst !== e.data) begin
                    errors++;
                    $display("FAIL deliv pc got=%h exp=%h inst got=%h exp=%h",
                             inst_pc, e.pc, inst, e.data);
                end
            end
        end
        prev_valid = inst_valid;
        if (w_req_valid && w_ready) begin
            checks++;
            if (w_exp_req.size() == 0) begin
                errors++;
                $display("FAIL wrap_req_unexpected addr got=%h exp=none", w_req_addr);
            end else begin
                a = w_exp_req.pop_front();
                if (w_req_addr !== a) begin
                    errors++;
                    $display("FAIL wrap_req_addr got=%h exp=%h", w_req_addr, a);
                end
            end
        end
        if (w_inst_valid && !w_prev_valid) begin
            w_deliv_pc.push_back(w_inst_pc);
            w_deliv_inst.push_back(w_inst);
        end
        w_prev_valid = w_inst_valid;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_fetch(input logic [31:0] a);
        deliv_t e;
        e.pc   = a;
        e.data = mem_word(a);
        exp_req.push_back(a);
        exp_deliv.push_back(e);
    endtask

    // Run until every expected request and delivery has been seen, then park in REQ.
    task automatic drain(input int bound);
        int n = 0;
        while ((exp_req.size() != 0 || exp_deliv.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        imem_req_ready = 1'b0;
        checks++;
        if (exp_req.size() != 0 || exp_deliv.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout req_left got=%0d deliv_left got=%0d exp=0",
                     exp_req.size(), exp_deliv.size());
            exp_req.delete();
            exp_deliv.delete();
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; w_rstn = 1'b0;
        redirect_valid = 1'b0; redirect_addr = 32'h0; stall = 1'b0;
        imem_req_ready = 1'b0; w_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids req_valid got=%b inst_valid got=%b exp=0 0",
                     imem_req_valid, inst_valid);
        end
        checks++;
        if (inst !== 32'h0 || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_inst inst got=%h inst_pc got=%h exp=0 0", inst, inst_pc);
        end
        checks++;
        if (imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc got=%h exp=00000000", imem_req_addr);
        end
        checks++;
        if (w_req_addr !== 32'hFFFF_FFFC || w_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_pc_wrap got=%h valid got=%b exp=fffffffc 0", w_req_addr, w_req_valid);
        end
        rstn = 1'b1;
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req valid got=%b addr got=%h exp=1 00000000",
                     imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_sequential();
        deliv_cyc.delete();
        mem_lat = 1;
        push_fetch(32'h0);
        push_fetch(32'h4);
        push_fetch(32'h8);
        imem_req_ready = 1'b1;
        drain(60);
        checks++;
        if (deliv_cyc.size() != 3) begin
            errors++;
            $display("FAIL seq_count got=%0d exp=3", deliv_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (deliv_cyc[i] - deliv_cyc[i-1] != 3) begin
                    errors++;
                    $display("FAIL seq_spacing[%0d] got=%0d exp=3", i, deliv_cyc[i] - deliv_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int n = 0;
        push_fetch(32'hC);
        imem_req_ready = 1'b1;
        while (!inst_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!inst_valid) begin
            errors++;
            $display("FAIL stall_wait_valid got=0 exp=1");
        end
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || inst !== mem_word(32'hC) || inst_pc !== 32'hC
                || imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d] valid got=%b inst got=%h pc got=%h req got=%b exp=1 %h 0000000c 0",
                         i, inst_valid, inst, inst_pc, imem_req_valid, mem_word(32'hC));
            end
        end
        push_fetch(32'h10);
        stall = 1'b0;
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release req got=%b addr got=%h valid got=%b exp=1 00000010 0",
                     imem_req_valid, imem_req_addr, inst_valid);
        end
        drain(30);
    endtask

    task automatic test_redirect_wait();
        exp_req.push_back(32'h14);
        mem_lat = 2;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h100;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_wait_kill valid got=%b req got=%b exp=0 0", inst_valid, imem_req_valid);
        end
        mem_lat = 1;
        push_fetch(32'h100);
        imem_req_ready = 1'b1;
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_wait_req req got=%b addr got=%h valid got=%b exp=1 00000100 0",
                     imem_req_valid, imem_req_addr, inst_valid);
        end
        drain(30);
    endtask

    task automatic test_redirect_rsp();
        exp_req.push_back(32'h104);
        mem_lat = 1;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h203;
        push_fetch(32'h200);
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_rsp_req req got=%b addr got=%h valid got=%b exp=1 00000200 0",
                     imem_req_valid, imem_req_addr, inst_valid);
        end
        imem_req_ready = 1'b1;
        drain(30);
    endtask

    task automatic test_reset_mid();
        exp_req.push_back(32'h204);
        mem_lat = 3;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rstn = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || imem_req_addr !== 32'h0 || inst !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid req got=%b valid got=%b addr got=%h inst got=%h exp=0 0 00000000 00000000",
                     imem_req_valid, inst_valid, imem_req_addr, inst);
        end
        tick();
        rstn = 1'b1;
        mem_lat = 1;
        push_fetch(32'h0);
        tick();
        imem_req_ready = 1'b1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_req req got=%b addr got=%h exp=1 00000000",
                     imem_req_valid, imem_req_addr);
        end
        drain(30);
    endtask

    task automatic test_wrap();
        int n = 0;
        w_exp_req.push_back(32'hFFFF_FFFC);
        w_exp_req.push_back(32'h0000_0000);
        w_exp_req.push_back(32'h0000_0004);
        w_rstn  = 1'b1;
        w_ready = 1'b1;
        while (w_exp_req.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        w_ready = 1'b0;
        checks++;
        if (w_exp_req.size() != 0) begin
            errors++;
            $display("FAIL wrap_timeout left got=%0d exp=0", w_exp_req.size());
        end
        checks++;
        if (w_deliv_pc.size() < 2) begin
            errors++;
            $display("FAIL wrap_deliv_count got=%0d exp=2", w_deliv_pc.size());
        end else if (w_deliv_pc[0] !== 32'hFFFF_FFFC || w_deliv_pc[1] !== 32'h0
                     || w_deliv_inst[0] !== 32'h13) begin
            errors++;
            $display("FAIL wrap_deliv pc0 got=%h pc1 got=%h inst got=%h exp=fffffffc 00000000 00000013",
                     w_deliv_pc[0], w_deliv_pc[1], w_deliv_inst[0]);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_rsp();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
